// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: mode encodings, flag bit indices,
// FSM state encoding and the flag vector width.
package alu_seq_pkg;

  localparam int unsigned FLAGS_W = 6;
  localparam int unsigned MODE_W  = 4;

  // Flag vector bit order, MSB to LSB: S, Z, H, PV, N, C
  localparam int unsigned F_C  = 0;
  localparam int unsigned F_N  = 1;
  localparam int unsigned F_PV = 2;
  localparam int unsigned F_H  = 3;
  localparam int unsigned F_Z  = 4;
  localparam int unsigned F_S  = 5;

  typedef enum logic [MODE_W-1:0] {
    MODE_ADD = 4'd0,
    MODE_ADC = 4'd1,
    MODE_SUB = 4'd2,
    MODE_SBC = 4'd3,
    MODE_AND = 4'd4,
    MODE_OR  = 4'd5,
    MODE_XOR = 4'd6,
    MODE_CP  = 4'd7,
    MODE_MUL = 4'd8,
    MODE_DIV = 4'd9
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Even parity: 1 when the byte holds an even number of ones
  function automatic logic even_par8(input logic [7:0] v);
    return ~(^v);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq.
interface alu_seq_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FLAGS_W = alu_seq_pkg::FLAGS_W
);
  import alu_seq_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [MODE_W-1:0]   mode;
  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic [FLAGS_W-1:0]  flags_in;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    result_lo;
  logic [WIDTH-1:0]    result_hi;
  logic [FLAGS_W-1:0]  flags_out;

  modport master (
    output in_valid, mode, op_a, op_b, flags_in, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, flags_out
  );

  modport slave (
    input  in_valid, mode, op_a, op_b, flags_in, out_ready,
    output in_ready, out_valid, result_lo, result_hi, flags_out
  );

endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per
// cycle, WIDTH steps after start. The next-step values are exposed
// combinationally so the caller can capture the final result on the last step.
module alu_seq_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_lo_c,
  output logic [WIDTH-1:0] o_hi_c
);
  import alu_seq_pkg::*;

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic             r_busy;
  logic             r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

  // One iteration step: hi/lo form the partial product or remainder/quotient
  always_comb begin
    w_add  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_sh   = {r_hi, r_lo[WIDTH-1]};
    w_diff = w_sh - {1'b0, r_b};
    w_ge   = ~w_diff[WIDTH];
    if (r_div) begin
      w_hi_nxt = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_nxt = w_add[WIDTH:1];
      w_lo_nxt = {w_add[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_done_c = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign o_lo_c   = w_lo_nxt;
  assign o_hi_c   = w_hi_nxt;

  // Operand load on start, then WIDTH iteration steps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_div  <= i_is_div;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= i_a;
      r_b    <= i_b;
    end else if (r_busy) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (o_done_c) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake. Add/sub/logic/compare complete
// in one cycle; MUL/DIV iterate one bit per cycle when ALU_SEQ_MULDIV_EN is
// defined, otherwise they behave as unused modes (result = op_a, flags pass).
module alu_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned FLAGS_W = alu_seq_pkg::FLAGS_W
) (
  input  logic     clk,
  input  logic     reset_n,
  alu_seq_if.slave bus
);
  import alu_seq_pkg::*;

  state_e              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_lo;
  logic [WIDTH-1:0]    r_hi;
  logic [FLAGS_W-1:0]  r_flags;

  logic                w_accept;
  logic                w_sub;
  logic                w_cin;
  logic [WIDTH-1:0]    w_bx;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH-1:0]    w_logic;
  logic [WIDTH-1:0]    w_lo1;
  logic [WIDTH-1:0]    w_hi1;
  logic [FLAGS_W-1:0]  w_fl1;
  logic                w_iter_req;

  assign w_accept = r_in_ready && bus.in_valid;

  // Add/sub operand conditioning: subtract adds ~op_b with inverted borrow-in
  always_comb begin
    w_sub = (bus.mode == MODE_SUB) || (bus.mode == MODE_SBC) || (bus.mode == MODE_CP);
    case (bus.mode)
      MODE_ADC:          w_cin = bus.flags_in[F_C];
      MODE_SUB, MODE_CP: w_cin = 1'b1;
      MODE_SBC:          w_cin = ~bus.flags_in[F_C];
      default:           w_cin = 1'b0;
    endcase
    w_bx  = w_sub ? ~bus.op_b : bus.op_b;
    w_sum = {1'b0, bus.op_a} + {1'b0, w_bx} + (WIDTH+1)'(w_cin);
  end

  // Single-cycle result and flags, computed from the request at acceptance
  always_comb begin
    w_lo1   = '0;
    w_hi1   = '0;
    w_fl1   = '0;
    w_logic = '0;
    case (bus.mode)
      MODE_ADD, MODE_ADC, MODE_SUB, MODE_SBC, MODE_CP: begin
        w_lo1        = (bus.mode == MODE_CP) ? bus.op_a : w_sum[WIDTH-1:0];
        w_fl1[F_S]   = w_sum[WIDTH-1];
        w_fl1[F_Z]   = (w_sum[WIDTH-1:0] == '0);
        // carry into bit 4 recovered from the sum bit
        w_fl1[F_H]   = (bus.op_a[4] ^ w_bx[4] ^ w_sum[4]) ^ w_sub;
        w_fl1[F_PV]  = (bus.op_a[WIDTH-1] == w_bx[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != bus.op_a[WIDTH-1]);
        w_fl1[F_N]   = w_sub;
        w_fl1[F_C]   = w_sum[WIDTH] ^ w_sub;
      end
      MODE_AND, MODE_OR, MODE_XOR: begin
        if (bus.mode == MODE_AND)     w_logic = bus.op_a & bus.op_b;
        else if (bus.mode == MODE_OR) w_logic = bus.op_a | bus.op_b;
        else                          w_logic = bus.op_a ^ bus.op_b;
        w_lo1       = w_logic;
        w_fl1[F_S]  = w_logic[WIDTH-1];
        w_fl1[F_Z]  = (w_logic == '0);
        w_fl1[F_H]  = (bus.mode == MODE_AND);
        w_fl1[F_PV] = even_par8(w_logic[7:0]);
      end
`ifdef ALU_SEQ_MULDIV_EN
      MODE_DIV: begin
        // only reaches this path on divide-by-zero
        w_lo1       = '1;
        w_hi1       = bus.op_a;
        w_fl1[F_S]  = 1'b1;
        w_fl1[F_N]  = 1'b1;
        w_fl1[F_PV] = 1'b1;
        w_fl1[F_C]  = 1'b1;
      end
      MODE_MUL: w_lo1 = '0;
`endif
      default: begin
        w_lo1 = bus.op_a;
        w_fl1 = bus.flags_in;
      end
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic               r_is_div;
  logic               w_md_done;
  logic [WIDTH-1:0]   w_md_lo;
  logic [WIDTH-1:0]   w_md_hi;
  logic [FLAGS_W-1:0] w_fl_md;

  assign w_iter_req = (bus.mode == MODE_MUL) ||
                      ((bus.mode == MODE_DIV) && (bus.op_b != '0));

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_accept && w_iter_req),
    .i_is_div (bus.mode == MODE_DIV),
    .i_a      (bus.op_a),
    .i_b      (bus.op_b),
    .o_done_c (w_md_done),
    .o_lo_c   (w_md_lo),
    .o_hi_c   (w_md_hi)
  );

  // Flags for a completed multiply or divide
  always_comb begin
    w_fl_md = '0;
    if (r_is_div) begin
      w_fl_md[F_Z] = (w_md_lo == '0);
      w_fl_md[F_S] = w_md_lo[WIDTH-1];
      w_fl_md[F_N] = 1'b1;
    end else begin
      w_fl_md[F_Z]  = ({w_md_hi, w_md_lo} == '0);
      w_fl_md[F_C]  = (w_md_hi != '0);
      w_fl_md[F_PV] = (w_md_hi != '0);
      w_fl_md[F_S]  = w_md_hi[WIDTH-1];
    end
  end
`else
  assign w_iter_req = 1'b0;
`endif

  // Control FSM with registered handshake outputs and results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_flags     <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      r_is_div    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_in_ready <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            r_is_div   <= (bus.mode == MODE_DIV);
`endif
            if (w_iter_req) begin
              r_state <= ST_ITER;
            end else begin
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
              r_lo        <= w_lo1;
              r_hi        <= w_hi1;
              r_flags     <= w_fl1;
            end
          end
        end
        ST_ITER: begin
`ifdef ALU_SEQ_MULDIV_EN
          if (w_md_done) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_lo        <= w_md_lo;
            r_hi        <= w_md_hi;
            r_flags     <= w_fl_md;
          end
`else
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
`endif
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result_lo = r_lo;
  assign bus.result_hi = r_hi;
  assign bus.flags_out = r_flags;

endmodule
